// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the EX stage and the HI/LO multiply/divide unit.
// The pipeline side (master) issues operations and the flush; the unit (slave)
// returns the busy/stall/done status and the architectural HI/LO contents.
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, cancel,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, cancel,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit sitting beside the EX-stage ALU.
// MULT/MULTU finish after MUL_CYCLES cycles, DIV/DIVU run a restoring radix-2
// divider for WIDTH cycles followed by a sign-fixup cycle, and MTHI/MTLO write
// the register pair in a single cycle without ever raising busy.
// While an operation is in flight the pipeline is frozen through stall; an
// exception flush (cancel) abandons the operation and leaves HI/LO untouched.
module hilo_muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  hilo_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_RSVD  = 3'b111
  } op_t;

  // One shared down-counter serves both the multiply latency and the
  // per-bit divide iteration, so it is sized for the larger of the two.
  localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Multiply operands, held for the whole multicycle window.
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_signed;

  // Divider datapath: partial remainder, dividend/quotient shift register,
  // divisor magnitude and the sign/exception bookkeeping for the fixup cycle.
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;
  logic [WIDTH-1:0] a_save;

  // Architectural state.
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  // Request decode.
  logic             is_mul_op;
  logic             is_div_op;
  logic             is_signed_div;
  logic             accept;

  // Operand conditioning for the divider.
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Multiplier: both operands are extended to 2*WIDTH so the low 2*WIDTH bits
  // of one unsigned product give the correct signed or unsigned result.
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] product;

  // One restoring-division step.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // Sign-corrected results for the fixup cycle.
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign is_mul_op     = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign is_div_op     = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign is_signed_div = (bus.op == OP_DIV);
  assign accept        = bus.start && !bus.cancel && (state == IDLE);

  assign a_neg = is_signed_div && bus.src_a[WIDTH-1];
  assign b_neg = is_signed_div && bus.src_b[WIDTH-1];
  assign a_mag = a_neg ? -bus.src_a : bus.src_a;
  assign b_mag = b_neg ? -bus.src_b : bus.src_b;

  assign ext_a   = mul_signed ? {{WIDTH{mul_a[WIDTH-1]}}, mul_a} : {{WIDTH{1'b0}}, mul_a};
  assign ext_b   = mul_signed ? {{WIDTH{mul_b[WIDTH-1]}}, mul_b} : {{WIDTH{1'b0}}, mul_b};
  assign product = ext_a * ext_b;

  // The top bit of diff is the borrow: with rem < dvs the shifted partial
  // remainder is below 2*dvs, so a successful subtract never sets it.
  assign shifted  = {rem, quo[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], q_bit};

  assign quo_fix = neg_q ? -quo : quo;
  assign rem_fix = neg_r ? -rem : rem;

  // Stall is combinational so a multicycle op freezes the pipe in the very
  // cycle it is presented; MTHI/MTLO complete in one edge and never stall.
  assign bus.stall = (state != IDLE) || (bus.start && (is_mul_op || is_div_op) && (state == IDLE));
  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  // Sequencer: accepts requests in IDLE, iterates MUL/DIV, applies signs in FIX
  // and raises a one-cycle done as HI/LO are written; cancel always wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_signed <= 1'b0;
      rem        <= '0;
      quo        <= '0;
      dvs        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_zero   <= 1'b0;
      a_save     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (bus.op)
              OP_MTHI: hi_q <= bus.src_a;
              OP_MTLO: lo_q <= bus.src_a;
              OP_MULT, OP_MULTU: begin
                mul_a      <= bus.src_a;
                mul_b      <= bus.src_b;
                mul_signed <= (bus.op == OP_MULT);
                cnt        <= CNT_MUL;
                state      <= MUL;
              end
              OP_DIV, OP_DIVU: begin
                rem      <= '0;
                quo      <= a_mag;
                dvs      <= b_mag;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                div_zero <= (bus.src_b == '0);
                a_save   <= bus.src_a;
                cnt      <= CNT_DIV;
                state    <= DIV;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          if (bus.cancel) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            hi_q   <= product[2*WIDTH-1:WIDTH];
            lo_q   <= product[WIDTH-1:0];
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DIV: begin
          if (bus.cancel) begin
            state <= IDLE;
          end else begin
            rem <= rem_next;
            quo <= quo_next;
            if (cnt == '0) begin
              state <= FIX;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end
        FIX: begin
          if (bus.cancel) begin
            state <= IDLE;
          end else begin
            if (div_zero) begin
              lo_q <= '1;
              hi_q <= a_save;
            end else begin
              lo_q <= quo_fix;
              hi_q <= rem_fix;
            end
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed cases for the documented
// corner results plus randomized MULT/MULTU/DIV/DIVU checked against a plain
// arithmetic reference model, with flush, reset and back-to-back scenarios.
module tb_hilo_muldiv_unit;

  localparam int WIDTH      = 32;
  localparam int MUL_CYCLES = 2;
  localparam int DIV_LAT    = WIDTH + 1;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [2:0]  MUL_OP  [4] = '{OP_MULT, OP_MULTU, OP_MULT, OP_MULTU};
  localparam logic [31:0] MUL_A   [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h8000_0000, 32'hFFFF_FFFF};
  localparam logic [31:0] MUL_B   [4] = '{32'h0000_0003, 32'h0000_0003, 32'h8000_0000, 32'hFFFF_FFFF};
  localparam logic [63:0] MUL_EXP [4] = '{64'hFFFF_FFFF_FFFF_FFFA, 64'h0000_0002_FFFF_FFFA,
                                          64'h4000_0000_0000_0000, 64'hFFFF_FFFE_0000_0001};

  localparam logic [2:0]  DIV_OP [7] = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIVU};
  localparam logic [31:0] DIV_A  [7] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd5,
                                         32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF};
  localparam logic [31:0] DIV_B  [7] = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0,
                                         32'd0, 32'hFFFF_FFFE, 32'd1};
  localparam logic [31:0] DIV_LO [7] = '{32'hFFFF_FFFD, 32'd3, 32'h8000_0000, 32'hFFFF_FFFF,
                                         32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
  localparam logic [31:0] DIV_HI [7] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd5,
                                         32'hFFFF_FFF9, 32'd1, 32'd0};

  logic clk = 1'b0;
  logic resetn;
  int   n_cmp = 0;
  int   n_fail = 0;

  hilo_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  hilo_muldiv_unit #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference results from plain arithmetic; returns {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa;
    int          sb;
    longint      p;
    logic [63:0] r;
    sa = int'(a);
    sb = int'(b);
    r  = '0;
    case (op)
      OP_MULT: begin
        p = longint'(sa) * longint'(sb);
        r = 64'(p);
      end
      OP_MULTU: r = {32'h0, a} * {32'h0, b};
      OP_DIV: begin
        if (b == 32'd0)                                    r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else                                               r = {32'(sa % sb), 32'(sa / sb)};
      end
      OP_DIVU: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else            r = {a % b, a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one accept edge.
  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    tick();
    bus.start = 1'b0;
    bus.op    = OP_NONE;
  endtask

  // Bounded wait for done; cycles counts edges after the accept edge.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #3;
    n_cmp++; if (bus.hi !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_hi: got %h, expected 0", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_lo: got %h, expected 0", bus.lo); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b, expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b, expected 0", bus.done); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall: got %b, expected 0", bus.stall); end
    tick();
    tick();
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_mul();
    int cycles;
    for (int i = 0; i < 4; i++) begin
      drive(MUL_OP[i], MUL_A[i], MUL_B[i]);
      wait_done(cycles);
      n_cmp++; if (cycles !== MUL_CYCLES) begin n_fail++; $display("[TB] FAIL mul_latency[%0d]: got %0d, expected %0d", i, cycles, MUL_CYCLES); end
      n_cmp++; if (bus.hi !== MUL_EXP[i][63:32]) begin n_fail++; $display("[TB] FAIL mul_hi[%0d]: got %h, expected %h", i, bus.hi, MUL_EXP[i][63:32]); end
      n_cmp++; if (bus.lo !== MUL_EXP[i][31:0]) begin n_fail++; $display("[TB] FAIL mul_lo[%0d]: got %h, expected %h", i, bus.lo, MUL_EXP[i][31:0]); end
      n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL mul_stall_at_done[%0d]: got %b, expected 0", i, bus.stall); end
      tick();
      n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL mul_done_pulse[%0d]: got %b, expected 0", i, bus.done); end
    end
  endtask

  task automatic test_div();
    int cycles;
    for (int i = 0; i < 7; i++) begin
      drive(DIV_OP[i], DIV_A[i], DIV_B[i]);
      n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL div_busy[%0d]: got %b, expected 1", i, bus.busy); end
      wait_done(cycles);
      n_cmp++; if (cycles !== DIV_LAT) begin n_fail++; $display("[TB] FAIL div_latency[%0d]: got %0d, expected %0d", i, cycles, DIV_LAT); end
      n_cmp++; if (bus.lo !== DIV_LO[i]) begin n_fail++; $display("[TB] FAIL div_lo[%0d]: got %h, expected %h", i, bus.lo, DIV_LO[i]); end
      n_cmp++; if (bus.hi !== DIV_HI[i]) begin n_fail++; $display("[TB] FAIL div_hi[%0d]: got %h, expected %h", i, bus.hi, DIV_HI[i]); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL div_busy_at_done[%0d]: got %b, expected 0", i, bus.busy); end
      tick();
    end
  endtask

  task automatic test_random();
    int          cycles;
    int          lat;
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_r;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(1, 4));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 17));
        2: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      exp_r = ref_result(o, a, b);
      lat   = (o == OP_MULT || o == OP_MULTU) ? MUL_CYCLES : DIV_LAT;
      drive(o, a, b);
      wait_done(cycles);
      n_cmp++; if (cycles !== lat) begin n_fail++; $display("[TB] FAIL rand_latency[%0d] op=%0d: got %0d, expected %0d", i, o, cycles, lat); end
      n_cmp++; if (bus.hi !== exp_r[63:32]) begin n_fail++; $display("[TB] FAIL rand_hi[%0d] op=%0d a=%h b=%h: got %h, expected %h", i, o, a, b, bus.hi, exp_r[63:32]); end
      n_cmp++; if (bus.lo !== exp_r[31:0]) begin n_fail++; $display("[TB] FAIL rand_lo[%0d] op=%0d a=%h b=%h: got %h, expected %h", i, o, a, b, bus.lo, exp_r[31:0]); end
      if ($urandom_range(0, 1) == 0) tick();
    end
  endtask

  task automatic test_mthi_mtlo();
    int          cycles;
    logic [31:0] lo_before;
    lo_before = bus.lo;
    bus.start = 1'b1;
    bus.op    = OP_MTHI;
    bus.src_a = 32'h1234_5678;
    #1;
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL mthi_stall: got %b, expected 0", bus.stall); end
    tick();
    n_cmp++; if (bus.hi !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL mthi_hi: got %h, expected 12345678", bus.hi); end
    n_cmp++; if (bus.lo !== lo_before) begin n_fail++; $display("[TB] FAIL mthi_lo_kept: got %h, expected %h", bus.lo, lo_before); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL mthi_busy_done: got %b%b, expected 00", bus.busy, bus.done); end
    bus.op    = OP_MTLO;
    bus.src_a = 32'h9ABC_DEF0;
    tick();
    bus.start = 1'b0;
    bus.op    = OP_NONE;
    n_cmp++; if (bus.lo !== 32'h9ABC_DEF0) begin n_fail++; $display("[TB] FAIL mtlo_lo: got %h, expected 9abcdef0", bus.lo); end
    n_cmp++; if (bus.hi !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL mtlo_hi_kept: got %h, expected 12345678", bus.hi); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL mtlo_busy_done: got %b%b, expected 00", bus.busy, bus.done); end
    tick();
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL mtx_no_done: got %b, expected 0", bus.done); end

    // MTHI/MTLO presented while a divide is in flight must be ignored.
    drive(OP_DIVU, 32'd100, 32'd7);
    n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("[TB] FAIL busy_stall: got %b, expected 1", bus.stall); end
    drive(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
    n_cmp++; if (bus.hi !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL mthi_while_busy: got %h, expected 12345678", bus.hi); end
    drive(OP_MTLO, 32'hCAFE_F00D, 32'h0);
    n_cmp++; if (bus.lo !== 32'h9ABC_DEF0) begin n_fail++; $display("[TB] FAIL mtlo_while_busy: got %h, expected 9abcdef0", bus.lo); end
    wait_done(cycles);
    n_cmp++; if (cycles !== DIV_LAT - 2) begin n_fail++; $display("[TB] FAIL busy_div_latency: got %0d, expected %0d", cycles, DIV_LAT - 2); end
    n_cmp++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin n_fail++; $display("[TB] FAIL busy_div_result: got %h/%h, expected 0000000e/00000002", bus.lo, bus.hi); end
    tick();
  endtask

  task automatic test_cancel();
    logic done_seen;
    drive(OP_MTHI, 32'hA, 32'h0);
    drive(OP_MTLO, 32'hB, 32'h0);
    drive(OP_DIVU, 32'd1000, 32'd3);
    for (int i = 0; i < 9; i++) tick();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL cancel_busy: got %b, expected 0", bus.busy); end
    n_cmp++; if (bus.hi !== 32'hA || bus.lo !== 32'hB) begin n_fail++; $display("[TB] FAIL cancel_hilo: got %h/%h, expected 0000000a/0000000b", bus.hi, bus.lo); end
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) done_seen = 1'b1;
      tick();
    end
    n_cmp++; if (done_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL cancel_no_done: got %b, expected 0", done_seen); end

    // Cancel during the sign-fixup cycle still suppresses the write.
    drive(OP_DIVU, 32'd1000, 32'd3);
    for (int i = 0; i < WIDTH; i++) tick();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL cancel_fix: got done=%b busy=%b, expected 0 0", bus.done, bus.busy); end
    n_cmp++; if (bus.hi !== 32'hA || bus.lo !== 32'hB) begin n_fail++; $display("[TB] FAIL cancel_fix_hilo: got %h/%h, expected 0000000a/0000000b", bus.hi, bus.lo); end

    // Start and cancel together: nothing is accepted, MTHI included.
    bus.cancel = 1'b1;
    drive(OP_MULT, 32'd3, 32'd4);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL start_cancel_busy: got %b, expected 0", bus.busy); end
    drive(OP_MTHI, 32'h55, 32'h0);
    bus.cancel = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.done === 1'b1) done_seen = 1'b1;
      tick();
    end
    n_cmp++; if (done_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL start_cancel_done: got %b, expected 0", done_seen); end
    n_cmp++; if (bus.hi !== 32'hA || bus.lo !== 32'hB) begin n_fail++; $display("[TB] FAIL start_cancel_hilo: got %h/%h, expected 0000000a/0000000b", bus.hi, bus.lo); end
  endtask

  task automatic test_async_reset();
    drive(OP_MTHI, 32'h77, 32'h0);
    drive(OP_MTLO, 32'h88, 32'h0);
    drive(OP_DIV, 32'd99, 32'd5);
    for (int i = 0; i < 4; i++) tick();
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin n_fail++; $display("[TB] FAIL async_reset_hilo: got %h/%h, expected 0/0", bus.hi, bus.lo); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL async_reset_busy: got %b, expected 0", bus.busy); end
    @(negedge clk);
    resetn = 1'b1;
    tick();
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL after_reset_idle: got busy=%b done=%b, expected 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_back_to_back();
    int          cycles;
    logic [63:0] exp_r;
    drive(OP_MULT, 32'd6, 32'hFFFF_FFF9);
    wait_done(cycles);
    n_cmp++; if (bus.lo !== 32'hFFFF_FFD6 || bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL b2b_first: got %h/%h, expected ffffffff/ffffffd6", bus.hi, bus.lo); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_stall_drop: got %b, expected 0", bus.stall); end
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.src_a = 32'h0001_0000;
    bus.src_b = 32'h0003_0000;
    exp_r     = ref_result(OP_MULTU, 32'h0001_0000, 32'h0003_0000);
    #1;
    n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_stall_new: got %b, expected 1", bus.stall); end
    tick();
    bus.start = 1'b0;
    bus.op    = OP_NONE;
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_accept: got %b, expected 1", bus.busy); end
    wait_done(cycles);
    n_cmp++; if (cycles !== MUL_CYCLES) begin n_fail++; $display("[TB] FAIL b2b_latency: got %0d, expected %0d", cycles, MUL_CYCLES); end
    n_cmp++; if ({bus.hi, bus.lo} !== exp_r) begin n_fail++; $display("[TB] FAIL b2b_second: got %h%h, expected %h", bus.hi, bus.lo, exp_r); end
    tick();
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.op     = OP_NONE;
    bus.src_a  = '0;
    bus.src_b  = '0;
    bus.cancel = 1'b0;
    resetn     = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_random();
    test_mthi_mtlo();
    test_cancel();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit so a stuck DUT can never hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] time limit");
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with the architectural HI/LO register pair.
- Sits in EX beside the combinational ALU.
- Executes MULT/MULTU/DIV/DIVU iteratively and MTHI/MTLO in one cycle.
- Drives the stall request the pipeline controller uses to freeze IF..EX; flushable by exception.

Parameters:
- WIDTH, 32, operand/HI/LO width (even, >=8).
- MUL_CYCLES, 2, multiply latency in cycles from accept to done (>=1).

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  request valid for op/src_a/src_b this cycle
- op  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none)
- src_a  input  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO data)
- src_b  input  WIDTH  rt operand (divisor / multiplier)
- cancel  input  1  exception flush; aborts in-flight op
- busy  output  1  operation in flight
- stall  output  1  combinational: busy | (start & op in {001..100} & state==IDLE)
- done  output  1  one-cycle pulse, HI/LO updated on this edge
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (resetn=0, async): state=IDLE, hi=0, lo=0, busy=0, done=0, counters/partials cleared.
- States: IDLE, MUL, DIV, FIX. done is a registered pulse asserted in the cycle after the final edge.
- IDLE:
  - start & MTHI: hi<=src_a next edge, no busy, no done.
  - start & MTLO: lo<=src_a next edge, no busy, no done.
  - start & MULT/MULTU: latch operands, go MUL, cnt<=MUL_CYCLES-1.
  - start & DIV/DIVU: latch magnitudes (signed ops take abs value, record signs), go DIV, cnt<=WIDTH-1.
  - Ops none/111: no effect.
- MUL:
  - Product is the full 2*WIDTH result: signed for MULT, unsigned for MULTU.
  - cnt decrements each cycle; at cnt==0 {hi,lo}<=product and return IDLE.
  - Total: accept edge to update edge = MUL_CYCLES cycles.
- DIV:
  - Restoring radix-2 division, one quotient bit per cycle, WIDTH cycles, then FIX.
- FIX:
  - Apply signs: quotient negated if signs differ; remainder takes dividend sign.
  - lo<=quotient, hi<=remainder; return IDLE.
  - Total DIV latency: WIDTH+1 cycles.
- Divide by zero (src_b==0): full latency still taken; lo<=all ones, hi<=src_a unchanged. Applies to both DIV and DIVU.
- Signed overflow (DIV, src_a=most-negative, src_b=-1): lo<=most-negative, hi<=0.
- busy=1 in MUL/DIV/FIX; start is ignored while busy, MTHI/MTLO included (the pipeline is stalled).
- cancel:
  - In any non-IDLE state: return to IDLE on the next edge; hi/lo unchanged; no done.
  - In IDLE with start: cancel wins and the request is dropped, including MTHI/MTLO.
- Completion edge: done=1 for exactly one cycle. stall drops in the same cycle done rises, so the stalled instruction retires.
- A new start is accepted in the cycle done=1.
- Reset mid-operation: immediate return to reset values.

Test Plan:
- MULT src_a=0xFFFFFFFE (-2), src_b=0x00000003 -> after 2 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> done 33 cycles after accept, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 7/2 -> lo=3, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on back-to-back cycles -> hi/lo updated one edge after each, busy never 1, done never 1. MTHI while busy -> ignored.
- Preload hi=0xA, lo=0xB. Start DIVU, assert cancel at cycle 10 -> busy=0 next cycle, hi=0xA, lo=0xB, no done. Start+cancel same cycle -> nothing accepted.
- resetn pulsed low mid-DIV -> hi=lo=0, busy=0 asynchronously. Back-to-back MULT issued in the done cycle -> accepted, second done MUL_CYCLES later.
